// File: rtl/spi_frame_controller.sv
// spi_frame_controller: synchronizes an MCU SPI-style bus (sclk, cs_n, mosi),
// assembles LSB-first bytes into {address, word, word, ...} frames and issues
// one single-cycle register-write strobe per completed word.
// Optional feature macro: FRAME_CHECKSUM_EN (one XOR checksum byte per word).
module spi_frame_controller #(
  parameter int WORD_BYTES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    wr_valid,
  output logic [7:0]              wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_data,
  output logic                    busy,
  output logic                    frame_error
);

  localparam int DW = 8 * WORD_BYTES;
  localparam logic [2:0] LAST_BYTE = 3'(WORD_BYTES - 1);

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, ADDR, DATA, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif

  // Synchronizer pipelines; index 2 is the edge-detect history stage.
  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  logic sclk_rise, cs_fall, cs_rise, mosi_bit;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [DW-1:0]   data_q, data_d;
  logic [7:0]      addr_q, addr_d;
  logic            wr_valid_d, frame_error_d;
  logic [7:0]      wr_addr_d;
  logic [DW-1:0]   wr_data_d;
  logic [7:0]      new_byte;
  logic            byte_done;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  // Bring the asynchronous pins into the clk domain and keep one history stage.
  // The cs_n chain resets low so that a reset released while cs_n is already
  // low never looks like a fresh falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= 3'b000;
      cs_sync   <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, so the chain shifts by exactly one stage per clock.
      sclk_sync <= {sclk_sync[1:0], sclk};
      cs_sync   <= {cs_sync[1:0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] &  cs_sync[2];
  assign cs_rise   =  cs_sync[1] & ~cs_sync[2];
  assign mosi_bit  = mosi_sync[1];
  assign busy      = (state_q != IDLE);

  // Next-state, datapath and output-strobe logic for the frame sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    data_d        = data_q;
    addr_d        = addr_q;
    wr_valid_d    = 1'b0;
    wr_addr_d     = wr_addr;
    wr_data_d     = wr_data;
    frame_error_d = 1'b0;
    new_byte      = {mosi_bit, shift_q[7:1]};
    byte_done     = (bit_cnt_q == 3'd7);
`ifdef FRAME_CHECKSUM_EN
    csum = addr_q;
    for (int i = 0; i < WORD_BYTES; i++) csum = csum ^ data_q[8*i +: 8];
`endif

    if (cs_rise) begin
      // Frame closed: anything short of a byte or word boundary is malformed.
      // A coincident sclk rise is deliberately dropped here.
      frame_error_d = (bit_cnt_q != 3'd0) ||
                      ((state_q != IDLE) && (state_q != ADDR) && (byte_cnt_q != 3'd0));
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d    = ADDR;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 3'd0;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            shift_d   = new_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done) begin
              addr_d  = new_byte;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            shift_d   = new_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done) begin
              for (int i = 0; i < WORD_BYTES; i++)
                if (byte_cnt_q == 3'(i)) data_d[8*i +: 8] = new_byte;
              if (byte_cnt_q == LAST_BYTE) begin
`ifdef FRAME_CHECKSUM_EN
                // Counter stays non-zero so a frame ending before the checksum errors.
                byte_cnt_d = byte_cnt_q + 3'd1;
                state_d    = CHECK;
`else
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_q;
                wr_data_d  = data_d;
                addr_d     = addr_q + 8'd1;
                byte_cnt_d = 3'd0;
`endif
              end else begin
                byte_cnt_d = byte_cnt_q + 3'd1;
              end
            end
          end
        end
`ifdef FRAME_CHECKSUM_EN
        CHECK: begin
          if (sclk_rise) begin
            shift_d   = new_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done) begin
              if (csum == new_byte) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_q;
                wr_data_d  = data_q;
              end else begin
                frame_error_d = 1'b1;
              end
              addr_d     = addr_q + 8'd1;
              byte_cnt_d = 3'd0;
              state_d    = DATA;
            end
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the word buffer is reset with everything else; it is a handful of
      // flops, not a RAM, so a clean reset value costs nothing.
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 3'd0;
      shift_q     <= 8'd0;
      data_q      <= '0;
      addr_q      <= 8'd0;
      wr_valid    <= 1'b0;
      wr_addr     <= 8'd0;
      wr_data     <= '0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      wr_valid    <= wr_valid_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      frame_error <= frame_error_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_controller.sv
// Bench for spi_frame_controller: directed vector table, hand-written reset and
// corner sequences, and randomized frames against a frame-level reference model.
module tb_spi_frame_controller;

  localparam int WB = 3;
  localparam int DW = 8 * WB;
`ifdef FRAME_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk, rst, sclk, cs_n, mosi;
  logic          wr_valid, busy, frame_error;
  logic [7:0]    wr_addr;
  logic [DW-1:0] wr_data;

  spi_frame_controller #(.WORD_BYTES(WB)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [39:0] got_q[$];
  logic [39:0] exp_q[$];
  int          err_seen = 0;
  int          exp_err  = 0;
  logic        prev_valid = 1'b0;

  typedef struct {
    logic [127:0] bytes;
    int           nbits;
    bit           coincide;
    int           nwr;
    logic [39:0]  w0;
    logic [39:0]  w1;
    int           nerr;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Collect every write strobe and error pulse seen on the outputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid) begin
        check("wr_valid_width", 64'(prev_valid), 64'(0));
        got_q.push_back({wr_addr, 32'(wr_data)});
      end
      if (frame_error) err_seen++;
    end
    prev_valid = wr_valid;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    wait_n(5);
    sclk = 1'b1;
    wait_n(5);
    sclk = 1'b0;
  endtask

  // Drive one frame: bit i of 'bytes' is the i-th bit on the wire.
  task automatic run_frame(input logic [127:0] bytes, input int nbits, input bit coincide);
    cs_n = 1'b0;
    wait_n(6);
    check("busy_open", busy, 1);
    for (int i = 0; i < nbits; i++) begin
      if (coincide && i == nbits - 1) begin
        mosi = bytes[i];
        wait_n(5);
        sclk = 1'b1;
        cs_n = 1'b1;
        wait_n(5);
        sclk = 1'b0;
      end else begin
        send_bit(bytes[i]);
      end
    end
    if (!coincide) begin
      wait_n(6);
      cs_n = 1'b1;
    end
    wait_n(8);
  endtask

  // Frame-level reference: split the received whole bytes into address and
  // word units and decide writes/errors from the frame rules directly.
  task automatic model_frame(input logic [127:0] bytes, input int nbits);
    int          nfull, unit, base;
    logic [7:0]  a, x;
    logic [31:0] d;
    nfull = nbits / 8;
    unit  = WB + CS;
    exp_q.delete();
    exp_err = 0;
    if (nfull >= 1) begin
      a = bytes[7:0];
      for (int w = 0; 1 + (w + 1) * unit <= nfull; w++) begin
        base = 1 + w * unit;
        d = '0;
        x = a;
        for (int k = 0; k < WB; k++) begin
          d[8*k +: 8] = bytes[8*(base + k) +: 8];
          x = x ^ bytes[8*(base + k) +: 8];
        end
        if (CS == 0 || x == bytes[8*(base + WB) +: 8]) exp_q.push_back({a, d});
        else exp_err++;
        a = a + 8'd1;
      end
    end
    if ((nbits % 8) != 0 || (nfull >= 1 && ((nfull - 1) % unit) != 0)) exp_err++;
  endtask

  task automatic compare_frame(input string tag, input int idx);
    check($sformatf("%s%0d_nwr", tag, idx), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s%0d_wr%0d", tag, idx, i), got_q[i], exp_q[i]);
    check($sformatf("%s%0d_err", tag, idx), err_seen, exp_err);
    check($sformatf("%s%0d_busy", tag, idx), busy, 0);
    if (exp_q.size() > 0)
      check($sformatf("%s%0d_hold", tag, idx), {wr_addr, 32'(wr_data)}, exp_q[exp_q.size() - 1]);
    got_q.delete();
    err_seen = 0;
  endtask

  task automatic add_vec(input logic [127:0] bytes, input int nbits, input bit coincide,
                         input int nwr, input logic [39:0] w0, input logic [39:0] w1,
                         input int nerr);
    vec_t v;
    v.bytes = bytes; v.nbits = nbits; v.coincide = coincide;
    v.nwr = nwr; v.w0 = w0; v.w1 = w1; v.nerr = nerr;
    vecs.push_back(v);
  endtask

  logic [127:0] fb;
  logic [7:0]   ra, rx, rb;
  int           nb, nw, nbits;

  initial begin
`ifdef FRAME_CHECKSUM_EN
    add_vec(128'h0133221101, 40, 0, 1, {8'h01, 32'h332211}, 40'h0, 0);
    add_vec(128'h0033221101, 40, 0, 0, 40'h0, 40'h0, 1);
    add_vec(128'h42, 8, 0, 0, 40'h0, 40'h0, 0);
    add_vec(128'h33221101, 32, 0, 0, 40'h0, 40'h0, 1);
    add_vec(128'h02000002FE000001FF, 72, 0, 2, {8'hFF, 32'h000001}, {8'h00, 32'h000002}, 0);
    add_vec(128'h06030201000000AA05, 72, 0, 1, {8'h06, 32'h030201}, 40'h0, 1);
    add_vec(128'h0, 0, 0, 0, 40'h0, 40'h0, 0);
    add_vec(128'h0133221101, 40, 1, 0, 40'h0, 40'h0, 1);
`else
    add_vec(128'h36C99610, 32, 0, 1, {8'h10, 32'h36C996}, 40'h0, 0);
    add_vec(128'h00000200_0001FF, 56, 0, 2, {8'hFF, 32'h000001}, {8'h00, 32'h000002}, 0);
    add_vec(128'hBBAA20, 21, 0, 0, 40'h0, 40'h0, 1);
    add_vec(128'h42, 8, 0, 0, 40'h0, 40'h0, 0);
    add_vec(128'h5A, 3, 0, 0, 40'h0, 40'h0, 1);
    add_vec(128'h4433221130, 40, 0, 1, {8'h30, 32'h332211}, 40'h0, 1);
    add_vec(128'h0, 0, 0, 0, 40'h0, 40'h0, 0);
    add_vec(128'h36C99650, 32, 1, 0, 40'h0, 40'h0, 1);
`endif

    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_n(4);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_error", frame_error, 0);
    rst = 1'b0;
    wait_n(8);
    check("post_rst_err", err_seen, 0);

    foreach (vecs[i]) begin
      exp_q.delete();
      if (vecs[i].nwr > 0) exp_q.push_back(vecs[i].w0);
      if (vecs[i].nwr > 1) exp_q.push_back(vecs[i].w1);
      exp_err = vecs[i].nerr;
      run_frame(vecs[i].bytes, vecs[i].nbits, vecs[i].coincide);
      compare_frame("vec", i);
    end

    // Reset in the middle of a frame, released while cs_n is still low.
    cs_n = 1'b0;
    wait_n(6);
    for (int i = 0; i < 12; i++) send_bit(1'(i % 2));
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_wr_valid", wr_valid, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_frame_error", frame_error, 0);
    wait_n(3);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
    check("rel_low_busy", busy, 0);
    check("rel_low_nwr", got_q.size(), 0);
    check("rel_low_addr", wr_addr, 0);
    cs_n = 1'b1;
    wait_n(8);
    check("rel_low_err", err_seen, 0);
    got_q.delete();
    err_seen = 0;
`ifdef FRAME_CHECKSUM_EN
    fb = 128'h0133221101; nbits = 40;
`else
    fb = 128'h36C99610; nbits = 32;
`endif
    model_frame(fb, nbits);
    run_frame(fb, nbits, 0);
    compare_frame("after_rst", 0);

    // Randomized frames against the reference model.
    for (int r = 0; r < 40; r++) begin
      fb = '0;
      ra = 8'($urandom);
      fb[7:0] = ra;
      nb = 1;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        rx = ra;
        for (int k = 0; k < WB; k++) begin
          rb = 8'($urandom);
          fb[8*nb +: 8] = rb;
          rx = rx ^ rb;
          nb++;
        end
        if (CS == 1) begin
          if ($urandom_range(0, 3) == 0) rx = rx ^ 8'($urandom_range(1, 255));
          fb[8*nb +: 8] = rx;
          nb++;
        end
        ra = ra + 8'd1;
      end
      nbits = nb * 8;
      if ($urandom_range(0, 3) == 0) nbits = $urandom_range(1, nbits - 1);
      model_frame(fb, nbits);
      run_frame(fb, nbits, 0);
      compare_frame("rand", r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
